mux_rr_arbiter: RTL and testbench

//  Round-robin arbiter that shares one keyed N:1 data mux between NR_REQ requesters.

---
 rtl/mux_rr_arbiter_pkg.sv | 18 +
 rtl/mux_rr_arbiter_if.sv | 19 +
 rtl/MuxKeyWithDefault.sv | 22 ++
 rtl/mux_rr_arbiter_rr_pick.sv | 22 ++
 rtl/mux_rr_arbiter.sv | 114 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 179 +++++++++++++++++
 6 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types and defaults for the round-robin mux arbiter.
package mux_rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_NR_REQ   = 4;
  localparam int DEF_DATA_LEN = 2;
  localparam int DEF_MAX_HOLD = 8;

  // Next rotation slot after idx, wrapping modulo n (n need not be a power of two).
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_if.sv
// Requester-side bus of the arbiter: request/data in, grant/select/result out.
interface mux_rr_arbiter_if
  import mux_rr_arbiter_pkg::*;
#(
  parameter int NR_REQ   = DEF_NR_REQ,
  parameter int DATA_LEN = DEF_DATA_LEN
);
  localparam int SEL_LEN = $clog2(NR_REQ);

  logic [NR_REQ-1:0]          req;
  logic [NR_REQ*DATA_LEN-1:0] data_in;
  logic [NR_REQ-1:0]          gnt;
  logic [SEL_LEN-1:0]         sel;
  logic                       out_valid;
  logic [DATA_LEN-1:0]        out_data;

  modport master (output req, data_in, input gnt, sel, out_valid, out_data);
  modport slave  (input req, data_in, output gnt, sel, out_valid, out_data);
endinterface

// File: rtl/MuxKeyWithDefault.sv
// Keyed N:1 mux: each lut entry is {key, data}; unmatched keys yield default_out.
module MuxKeyWithDefault #(
  parameter int NR_KEY   = 2,
  parameter int KEY_LEN  = 1,
  parameter int DATA_LEN = 1
) (
  output logic [DATA_LEN-1:0]                  out,
  input  logic [KEY_LEN-1:0]                   key,
  input  logic [DATA_LEN-1:0]                  default_out,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut
);
  localparam int PAIR_LEN = KEY_LEN + DATA_LEN;

  always_comb begin
    out = default_out;
    for (int i = 0; i < NR_KEY; i++) begin
      if (lut[i*PAIR_LEN+DATA_LEN +: KEY_LEN] == key) begin
        out = lut[i*PAIR_LEN +: DATA_LEN];
      end
    end
  end
endmodule

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin search: first set req bit at or after ptr, with wrap.
module rr_pick #(
  parameter int NR_REQ  = 4,
  parameter int SEL_LEN = $clog2(NR_REQ)
) (
  input  logic [NR_REQ-1:0]  req,
  input  logic [SEL_LEN-1:0] ptr,
  output logic               found,
  output logic [SEL_LEN-1:0] idx
);
  // Scan farthest-first so the candidate closest to ptr is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NR_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NR_REQ]) begin
        found = 1'b1;
        idx   = SEL_LEN'((int'(ptr) + k) % NR_REQ);
      end
    end
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter owning the select key of a shared keyed data mux,
// with forced rotation after MAX_HOLD cycles when other requesters wait.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int NR_REQ   = DEF_NR_REQ,
  parameter int DATA_LEN = DEF_DATA_LEN,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input logic            clk,
  input logic            rst,
  mux_rr_arbiter_if.slave bus
);
  localparam int SEL_LEN = $clog2(NR_REQ);
  localparam int HOLD_W  = $clog2(MAX_HOLD);
  localparam int LUT_W   = NR_REQ * (SEL_LEN + DATA_LEN);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD - 1);

  arb_state_t          state_reg;
  logic [NR_REQ-1:0]   gnt_reg;
  logic [SEL_LEN-1:0]  sel_reg;
  logic [SEL_LEN-1:0]  ptr_reg;
  logic [HOLD_W-1:0]   hold_cnt_reg;

  logic                pick_found;
  logic [SEL_LEN-1:0]  pick_idx;
  logic                others_waiting;
  logic [LUT_W-1:0]    lut;
  logic [DATA_LEN-1:0] mux_out;
  logic                out_valid;

  rr_pick #(.NR_REQ(NR_REQ), .SEL_LEN(SEL_LEN)) u_pick (
    .req   (bus.req),
    .ptr   (ptr_reg),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // gnt_reg is onehot(sel) while granting, so masking it leaves only the other requesters.
  assign others_waiting = |(bus.req & ~gnt_reg);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg    <= IDLE;
      gnt_reg      <= '0;
      sel_reg      <= '0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            state_reg    <= GRANT;
            gnt_reg      <= NR_REQ'(1) << pick_idx;
            sel_reg      <= pick_idx;
            ptr_reg      <= SEL_LEN'(wrap_inc(int'(pick_idx), NR_REQ));
            hold_cnt_reg <= '0;
          end
        end
        GRANT: begin
          // Release is checked first so it wins over a simultaneous forced rotation.
          if (!bus.req[sel_reg]) begin
            if (pick_found) begin
              gnt_reg      <= NR_REQ'(1) << pick_idx;
              sel_reg      <= pick_idx;
              ptr_reg      <= SEL_LEN'(wrap_inc(int'(pick_idx), NR_REQ));
              hold_cnt_reg <= '0;
            end else begin
              state_reg    <= IDLE;
              gnt_reg      <= '0;
              hold_cnt_reg <= '0;
            end
          end else if (hold_cnt_reg == HOLD_LIMIT && others_waiting) begin
            gnt_reg      <= NR_REQ'(1) << pick_idx;
            sel_reg      <= pick_idx;
            ptr_reg      <= SEL_LEN'(wrap_inc(int'(pick_idx), NR_REQ));
            hold_cnt_reg <= '0;
          end else if (hold_cnt_reg == HOLD_LIMIT) begin
            hold_cnt_reg <= '0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + HOLD_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
          gnt_reg   <= '0;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NR_REQ; gi++) begin : g_lut
    assign lut[gi*(SEL_LEN+DATA_LEN) +: SEL_LEN+DATA_LEN] =
      {SEL_LEN'(gi), bus.data_in[gi*DATA_LEN +: DATA_LEN]};
  end

  MuxKeyWithDefault #(.NR_KEY(NR_REQ), .KEY_LEN(SEL_LEN), .DATA_LEN(DATA_LEN)) u_mux (
    .out         (mux_out),
    .key         (sel_reg),
    .default_out ('0),
    .lut         (lut)
  );

  assign out_valid     = |gnt_reg;
  assign bus.gnt       = gnt_reg;
  assign bus.sel       = sel_reg;
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_valid ? mux_out : '0;

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_reg));
  a_valid_match : assert property (@(posedge clk) disable iff (!rst) out_valid == |gnt_reg);
  a_sel_owner   : assert property (@(posedge clk) disable iff (!rst) gnt_reg[sel_reg] == out_valid);
  a_sel_range   : assert property (@(posedge clk) disable iff (!rst) int'(sel_reg) < NR_REQ);
endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares each cycle.
module tb_mux_rr_arbiter;
  localparam int NR = 4;
  localparam int DL = 2;
  localparam int MH = 8;
  localparam int SL = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mux_rr_arbiter_if #(.NR_REQ(NR), .DATA_LEN(DL)) bus ();

  mux_rr_arbiter #(.NR_REQ(NR), .DATA_LEN(DL), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct packed {
    logic [NR-1:0] gnt;
    logic [SL-1:0] sel;
    logic          valid;
    logic [DL-1:0] data;
  } resp_t;

  resp_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int cycle_no = 0;

  // Reference model: who owns the mux, where the next search starts, how long the owner has held.
  int owner = -1;
  int next_from = 0;
  int tenure = 0;
  int last_key = 0;

  function automatic int first_waiting(input logic [NR-1:0] r, input int from);
    for (int k = 0; k < NR; k++) begin
      if (r[(from + k) % NR]) return (from + k) % NR;
    end
    return -1;
  endfunction

  function void award(input int i);
    owner     = i;
    last_key  = i;
    next_from = (i + 1) % NR;
    tenure    = 0;
  endfunction

  function void model_step(input logic rst_n, input logic [NR-1:0] r);
    logic [NR-1:0] others;
    if (!rst_n) begin
      owner = -1; next_from = 0; tenure = 0; last_key = 0;
      return;
    end
    if (owner < 0) begin
      if (r != '0) award(first_waiting(r, next_from));
      return;
    end
    others = r;
    others[owner] = 1'b0;
    if (!r[owner]) begin
      if (others != '0) award(first_waiting(r, next_from));
      else owner = -1;
    end else if (tenure == MH - 1 && others != '0) begin
      award(first_waiting(others, next_from));
    end else begin
      tenure = (tenure + 1) % MH;
    end
  endfunction

  task automatic drive(input logic rst_n, input logic [NR-1:0] r, input logic [NR*DL-1:0] d);
    resp_t e;
    @(negedge clk);
    rst         = rst_n;
    bus.req     = r;
    bus.data_in = d;
    model_step(rst_n, r);
    e.gnt   = '0;
    e.sel   = SL'(last_key);
    e.valid = (owner >= 0);
    e.data  = '0;
    if (owner >= 0) begin
      e.gnt[owner] = 1'b1;
      e.data       = d[owner*DL +: DL];
    end
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    resp_t e;
    resp_t a;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a.gnt   = bus.gnt;
      a.sel   = bus.sel;
      a.valid = bus.out_valid;
      a.data  = bus.out_data;
      tests++;
      cycle_no++;
      if (a !== e) begin
        fails++;
        $display("FAIL resp cycle %0d: got gnt=%b sel=%0d valid=%b data=%b, expected gnt=%b sel=%0d valid=%b data=%b",
                 cycle_no, a.gnt, a.sel, a.valid, a.data, e.gnt, e.sel, e.valid, e.data);
      end else begin
        $display("[TB] cycle %0d req=%b gnt=%b sel=%0d valid=%b data=%b ok",
                 cycle_no, bus.req, a.gnt, a.sel, a.valid, a.data);
      end
    end
  end

  initial begin
    logic [NR-1:0] r;
    bus.req     = '0;
    bus.data_in = '0;

    // Reset with all requesting, then release: requester 0 wins first.
    drive(1'b0, 4'b1111, 8'($urandom));
    drive(1'b0, 4'b1111, 8'($urandom));
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b1111, 8'($urandom));

    // Single requester 2 with data 2'b10, then drop.
    drive(1'b0, 4'b0000, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0100, 8'b00_10_00_00);
    for (int i = 0; i < 2; i++) drive(1'b1, 4'b0000, 8'b00_10_00_00);

    // Round robin: the current owner drops its request, everyone else keeps asking.
    drive(1'b0, 4'b0000, 8'h00);
    for (int i = 0; i < 12; i++) begin
      r = 4'b1111;
      if (owner >= 0) r[owner] = 1'b0;
      drive(1'b1, r, 8'($urandom));
    end

    // Forced rotation between 0 and 1, then a sole requester holding indefinitely.
    drive(1'b0, 4'b0000, 8'h00);
    for (int i = 0; i < 40; i++) drive(1'b1, 4'b0011, 8'($urandom));
    for (int i = 0; i < 20; i++) drive(1'b1, 4'b0001, 8'($urandom));

    // Owner 2 releases in the same cycle requester 3 arrives.
    drive(1'b0, 4'b0000, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0100, 8'($urandom));
    for (int i = 0; i < 2; i++) drive(1'b1, 4'b1000, 8'($urandom));

    // Reset while requester 1 owns the grant; pointer restarts at 0.
    drive(1'b0, 4'b0000, 8'h00);
    for (int i = 0; i < 3; i++) drive(1'b1, 4'b0010, 8'($urandom));
    drive(1'b0, 4'b0010, 8'($urandom));
    for (int i = 0; i < 2; i++) drive(1'b1, 4'b1111, 8'($urandom));

    // Fully random requests with occasional resets.
    for (int i = 0; i < 500; i++) begin
      drive(($urandom_range(63) != 0), 4'($urandom), 8'($urandom));
    end

    // Sticky requests: bits toggle rarely so hold limits are reached often.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < NR; b++) begin
        if ($urandom_range(11) == 0) r[b] = ~r[b];
      end
      drive(($urandom_range(199) != 0), r, 8'($urandom));
    end

    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d responses left unchecked, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
